// File: rtl/mem_pkg.sv
// Shared types and address helpers for the multiport instruction/data memory.
// Width helpers take the instance parameters so each instance derives its own geometry.
package mem_pkg;

   typedef enum logic {
      RDW_READ_OLD    = 1'b0,
      RDW_WRITE_FIRST = 1'b1
   } rdw_mode_e;

   // Response view at the default 32-bit word width.
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } mem_resp_t;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int offset_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int word_addr_bits(input int mem_depth);
      return $clog2(mem_depth);
   endfunction

   // Flags a byte address that is misaligned or beyond the last word.
   function automatic logic addr_check(input logic [63:0] addr, input int data_width,
                                       input int mem_depth);
      logic [63:0] off_mask;
      logic [63:0] limit;
      off_mask = (64'd1 << offset_bits(data_width)) - 64'd1;
      limit    = 64'(mem_depth) * 64'(be_width(data_width));
      return ((addr & off_mask) != 64'd0) || (addr >= limit);
   endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth response shift pipeline: a reset valid bit travelling with a generic payload.
// No back-pressure, so every stage simply advances each cycle.
module mem_resp_pipe #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_payload,
   output logic         out_valid,
   output logic [W-1:0] out_payload
);

   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [DEPTH-1:0][W-1:0] payload_q, payload_d;

   always_comb begin
      valid_d      = valid_q;
      payload_d    = payload_q;
      valid_d[0]   = in_valid;
      payload_d[0] = in_payload;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i]   = valid_q[i-1];
         payload_d[i] = payload_q[i-1];
      end
   end

   // NOTE: non-blocking updates make every stage sample its neighbour's pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= '0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign out_valid   = valid_q[DEPTH-1];
   assign out_payload = payload_q[DEPTH-1];

endmodule

// File: rtl/mem_multiport.sv
// Unified memory with NUM_RD_PORTS read-only ports and one read/write data port.
// Each port returns {valid, err, data} exactly READ_LATENCY cycles after its request.
module mem_multiport
   import mem_pkg::*;
#(
   parameter int    ADDR_WIDTH   = 32,
   parameter int    DATA_WIDTH   = 32,
   parameter int    MEM_DEPTH    = 16384,
   parameter int    NUM_RD_PORTS = 1,
   parameter int    READ_LATENCY = 1,
   parameter int    RDW_MODE     = 0,
   parameter string INIT_FILE    = ""
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_RD_PORTS-1:0]            rd_req,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD_PORTS-1:0]            rd_valid,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD_PORTS-1:0]            rd_err,
   input  logic                               dp_req,
   input  logic                               dp_we,
   input  logic [ADDR_WIDTH-1:0]              dp_addr,
   input  logic [DATA_WIDTH-1:0]              dp_wdata,
   input  logic [DATA_WIDTH/8-1:0]            dp_be,
   output logic                               dp_valid,
   output logic [DATA_WIDTH-1:0]              dp_rdata,
   output logic                               dp_err
);

   localparam int        BE_W      = be_width(DATA_WIDTH);
   localparam int        OFF_BITS  = offset_bits(DATA_WIDTH);
   localparam int        WORD_BITS = word_addr_bits(MEM_DEPTH);
   localparam int        NUM_PORTS = NUM_RD_PORTS + 1;
   localparam int        DP        = NUM_RD_PORTS;
   localparam int        PAY_W     = 2 + BE_W + DATA_WIDTH;
   localparam rdw_mode_e RDW       = (RDW_MODE == 1) ? RDW_WRITE_FIRST : RDW_READ_OLD;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [NUM_PORTS-1:0]                 req, err, fwd_hit;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
   logic [NUM_PORTS-1:0][WORD_BITS-1:0]  idx;
   logic [NUM_PORTS-1:0][PAY_W-1:0]      pay_in;
   logic [NUM_PORTS-1:0]                 valid_out, err_out;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_out;
   logic                                 wr_en;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      req     = {dp_req, rd_req};
      addr    = {dp_addr, rd_addr};
      err     = '0;
      idx     = '0;
      fwd_hit = '0;
      pay_in  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         err[p] = addr_check(64'(addr[p]), DATA_WIDTH, MEM_DEPTH);
         idx[p] = addr[p][OFF_BITS +: WORD_BITS];
      end
      wr_en = rst_n & dp_req & dp_we & ~err[DP];
      // Write-first forwarding carries the store bytes alongside the old-word read.
      for (int p = 0; p < NUM_PORTS; p++) begin
         fwd_hit[p] = (RDW == RDW_WRITE_FIRST) && (p != DP) && wr_en && !err[p]
                      && (idx[p] == idx[DP]);
         pay_in[p]  = {err[p], err[p] | ((p == DP) & dp_we),
                       fwd_hit[p] ? dp_be : {BE_W{1'b0}},
                       fwd_hit[p] ? dp_wdata : {DATA_WIDTH{1'b0}}};
      end
   end

   // NOTE: the array has no reset; contents survive rst_n and only pipeline control is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < BE_W; k++) begin
            if (dp_be[k]) mem[idx[DP]][8*k +: 8] <= dp_wdata[8*k +: 8];
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic                  pipe_valid, pipe_err, pipe_zero;
      logic [BE_W-1:0]       pipe_fbe;
      logic [DATA_WIDTH-1:0] pipe_fdata, rd_word_q, bram_word, merged;
      logic [PAY_W-1:0]      pay_out;

      always_ff @(posedge clk) rd_word_q <= mem[idx[p]];

      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] out_word_q;
         always_ff @(posedge clk) out_word_q <= rd_word_q;
         assign bram_word = out_word_q;
      end else begin : g_lat1
         assign bram_word = rd_word_q;
      end

      mem_resp_pipe #(.DEPTH(READ_LATENCY), .W(PAY_W)) u_pipe (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_valid    (req[p]),
         .in_payload  (pay_in[p]),
         .out_valid   (pipe_valid),
         .out_payload (pay_out)
      );

      assign {pipe_err, pipe_zero, pipe_fbe, pipe_fdata} = pay_out;

      always_comb begin
         merged = bram_word;
         for (int k = 0; k < BE_W; k++) begin
            if (pipe_fbe[k]) merged[8*k +: 8] = pipe_fdata[8*k +: 8];
         end
      end

      assign valid_out[p] = pipe_valid;
      assign err_out[p]   = pipe_valid & pipe_err;
      assign data_out[p]  = (pipe_valid && !pipe_zero) ? merged : '0;
   end

   assign rd_valid = valid_out[NUM_RD_PORTS-1:0];
   assign rd_err   = err_out[NUM_RD_PORTS-1:0];
   assign rd_data  = data_out[NUM_RD_PORTS-1:0];
   assign dp_valid = valid_out[DP];
   assign dp_err   = err_out[DP];
   assign dp_rdata = data_out[DP];

endmodule

// File: tb/tb_mem_multiport.sv
// Drives two memory instances (latency 1/read-old and latency 2/write-first) with one stimulus
// and compares every port each cycle against a word-array model with a response schedule.
module tb_mem_multiport;
   import mem_pkg::*;

   localparam int NRD = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NRD-1:0]   rd_req;
   logic [NRD*32-1:0] rd_addr;
   logic             dp_req, dp_we;
   logic [31:0]      dp_addr, dp_wdata;
   logic [3:0]       dp_be;

   logic [NRD-1:0]    a_rd_valid, a_rd_err, b_rd_valid, b_rd_err;
   logic [NRD*32-1:0] a_rd_data, b_rd_data;
   logic              a_dp_valid, a_dp_err, b_dp_valid, b_dp_err;
   logic [31:0]       a_dp_rdata, b_dp_rdata;

   mem_multiport #(.NUM_RD_PORTS(NRD), .READ_LATENCY(1), .RDW_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err),
      .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata), .dp_be(dp_be),
      .dp_valid(a_dp_valid), .dp_rdata(a_dp_rdata), .dp_err(a_dp_err)
   );

   mem_multiport #(.NUM_RD_PORTS(NRD), .READ_LATENCY(2), .RDW_MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err),
      .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata), .dp_be(dp_be),
      .dp_valid(b_dp_valid), .dp_rdata(b_dp_rdata), .dp_err(b_dp_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int        cyc = 0;
   bit [31:0] mm [int];
   mem_resp_t sched [2][3][8];

   function automatic bit bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 16384 * 4);
   endfunction

   function automatic bit [31:0] peek(input int w);
      return mm.exists(w) ? mm[w] : 32'h0;
   endfunction

   function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw,
                                       input logic [3:0] be);
      bit [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   function automatic logic [33:0] dut_resp(input int d, input int p);
      if (d == 0) begin
         case (p)
            0:       return {a_rd_valid[0], a_rd_err[0], a_rd_data[31:0]};
            1:       return {a_rd_valid[1], a_rd_err[1], a_rd_data[63:32]};
            default: return {a_dp_valid, a_dp_err, a_dp_rdata};
         endcase
      end
      case (p)
         0:       return {b_rd_valid[0], b_rd_err[0], b_rd_data[31:0]};
         1:       return {b_rd_valid[1], b_rd_err[1], b_rd_data[63:32]};
         default: return {b_dp_valid, b_dp_err, b_dp_rdata};
      endcase
   endfunction

   // Instance d has latency d+1, and instance 1 forwards same-word stores.
   always @(posedge clk) begin
      mem_resp_t   r;
      bit          st_ok;
      int          dw;
      logic [31:0] a;
      cyc++;
      if (!rst_n) begin
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 3; p++)
               for (int s = 0; s < 8; s++) sched[d][p][s] = '0;
      end else begin
         dw    = int'(dp_addr / 4);
         st_ok = dp_req && dp_we && !bad(dp_addr);
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NRD; p++) begin
               if (rd_req[p]) begin
                  a       = rd_addr[32*p +: 32];
                  r.valid = 1'b1;
                  r.err   = bad(a);
                  r.data  = '0;
                  if (!r.err) begin
                     r.data = peek(int'(a / 4));
                     if (d == 1 && st_ok && int'(a / 4) == dw) r.data = merge(r.data, dp_wdata, dp_be);
                  end
                  sched[d][p][(cyc + d) % 8] = r;
               end
            end
            if (dp_req) begin
               r.valid = 1'b1;
               r.err   = bad(dp_addr);
               r.data  = (r.err || dp_we) ? 32'h0 : peek(dw);
               sched[d][2][(cyc + d) % 8] = r;
            end
         end
         if (st_ok) mm[dw] = merge(peek(dw), dp_wdata, dp_be);
      end
   end

   always @(posedge clk) begin
      mem_resp_t e;
      #2;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 3; p++) begin
            e = sched[d][p][cyc % 8];
            check($sformatf("dut%0d port%0d cycle%0d", d, p, cyc), dut_resp(d, p), e);
            sched[d][p][cyc % 8] = '0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic dreq, input logic dwe, input logic [31:0] daddr,
                        input logic [31:0] dwdata, input logic [3:0] dbe,
                        input logic [1:0] rreq, input logic [31:0] a0, input logic [31:0] a1);
      dp_req   = dreq;
      dp_we    = dwe;
      dp_addr  = daddr;
      dp_wdata = dwdata;
      dp_be    = dbe;
      rd_req   = rreq;
      rd_addr  = {a1, a0};
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1, 1, 32'h0, 32'h0, 4'hF, 2'b11, 32'h10000, 32'h10000);
      repeat (3) step();
      check("b dp idle in reset", dut_resp(1, 2), 34'h0);
      rst_n = 1'b1;
      step();
      check("a first rd after release", dut_resp(0, 0), {2'b11, 32'h0});
      check("b no rd one cycle after release", dut_resp(1, 0), 34'h0);

      drive(1, 1, 32'h4, 32'h04040404, 4'hF, 2'b00, 32'h0, 32'h0);
      step();
      check("b first rd two cycles after release", dut_resp(1, 1), {2'b11, 32'h0});
      check("b first store response", dut_resp(1, 2), {2'b10, 32'h0});
      drive(1, 1, 32'h8, 32'h08080808, 4'hF, 2'b00, 32'h0, 32'h0);
      step();
      drive(1, 1, 32'h10, 32'h11223344, 4'hF, 2'b00, 32'h0, 32'h0);
      step();
      drive(1, 1, 32'h20, 32'h0, 4'hF, 2'b00, 32'h0, 32'h0);
      step();
      drive(1, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 2'b00, 32'h0, 32'h0);
      step();
      check("model byte merge", {2'b00, peek(4)}, {2'b00, 32'h11BB33DD});

      drive(1, 0, 32'h10, 32'h0, 4'h0, 2'b00, 32'h0, 32'h0);
      step();
      check("a byte-store load", dut_resp(0, 2), {2'b10, 32'h11BB33DD});

      drive(1, 1, 32'h20, 32'hDEADBEEF, 4'hF, 2'b01, 32'h20, 32'h0);
      step();
      check("a rdw read-old", dut_resp(0, 0), {2'b10, 32'h0});
      check("b byte-store load", dut_resp(1, 2), {2'b10, 32'h11BB33DD});

      drive(1, 1, 32'h22, 32'h12345678, 4'hF, 2'b10, 32'h0, 32'h10000);
      step();
      check("a misaligned store err", dut_resp(0, 2), {2'b11, 32'h0});
      check("a out-of-range read err", dut_resp(0, 1), {2'b11, 32'h0});
      check("b rdw write-first", dut_resp(1, 0), {2'b10, 32'hDEADBEEF});

      drive(1, 0, 32'h20, 32'h0, 4'h0, 2'b00, 32'h0, 32'h0);
      step();
      check("a word unchanged by bad store", dut_resp(0, 2), {2'b10, 32'hDEADBEEF});

      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 32'h0, 4'h0, 2'b11, 32'(i * 4), 32'h0);
         step();
      end

      drive(1, 1, 32'h8, 32'hCAFEF00D, 4'b0011, 2'b01, 32'h8, 32'h0);
      step();
      check("a partial rdw read-old", dut_resp(0, 0), {2'b10, 32'h08080808});
      drive(1, 1, 32'hFFFC, 32'h600DF00D, 4'hF, 2'b00, 32'h0, 32'h0);
      step();
      check("b partial rdw merged", dut_resp(1, 0), {2'b10, 32'h0808F00D});
      drive(0, 0, 32'h0, 32'h0, 4'h0, 2'b11, 32'hFFFC, 32'h6);
      step();
      check("a last word read", dut_resp(0, 0), {2'b10, 32'h600DF00D});
      check("a misaligned read err", dut_resp(0, 1), {2'b11, 32'h0});

      drive(1, 1, 32'h4, 32'h5A5A5A5A, 4'hF, 2'b00, 32'h0, 32'h0);
      step();
      drive(1, 0, 32'h8, 32'h0, 4'h0, 2'b00, 32'h0, 32'h0);
      step();
      rst_n = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 32'h0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) begin
         step();
         check("b no response for flushed load", dut_resp(1, 2), 34'h0);
      end

      drive(1, 0, 32'h4, 32'h0, 4'h0, 2'b00, 32'h0, 32'h0);
      step();
      check("a store before reset retained", dut_resp(0, 2), {2'b10, 32'h5A5A5A5A});
      drive(0, 0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 32'h0);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
